vad_decision_smoother: RTL and testbench
========================================

// Module: vad_decision_smoother
// PURPOSE
//  Post-processor between the DNN_0 core (ap_done/ap_return) and the VAD output pins.
//  Turns each float32 DNN result into a raw speech bit (exact-code or threshold mode).
//  Majority-votes the raw bits over a sliding window of WIN frames.
//  Applies on/off hysteresis plus a hangover counter to produce a stable speech flag.
// PARAMETERS
//  WIN          8             sliding-window length in frames, 1..32
//  VOTE_ON      5             votes needed to enter/re-enter speech, VOTE_OFF < VOTE_ON <= WIN
//  VOTE_OFF     2             votes at/below which speech ends (hangover starts)
//  HANG         4             extra speech frames reported after speech ends, 0..255
//  MODE         0             0: raw = (dnn_return == SPEECH_CODE); 1: float threshold
//  SPEECH_CODE  32'h3F800000  exact speech code (1.0f), MODE 0
//  THRESH       32'h3F000000  positive float32 threshold (0.5f), MODE 1
// PORTS
//  g_fast_clk    in   1              system clock, all logic on rising edge
//  rst_n         in   1              asynchronous reset, active low
//  dnn_done      in   1              one-cycle pulse, dnn_return valid
//  dnn_return    in   32             float32 DNN result
//  clear         in   1              synchronous flush of history and FSM
//  raw_valid     out  1              pulse, raw_decision updated
//  raw_decision  out  1              per-frame raw speech bit
//  vad_valid     out  1              pulse, smoothed decision updated
//  vad_speech    out  1              smoothed speech flag
//  vote_count    out  $clog2(WIN+1)  ones currently in window
//  hang_active   out  1              FSM is in HANGOVER
// BEHAVIOUR
//  Reset: all outputs 0; history, fill counter, vote_count, hang counter 0; FSM = SILENCE.
//  Raw bit, MODE 1: dnn_return[31]==0 && dnn_return[30:0] >= THRESH[30:0] (unsigned compare).
//   Negative values, including -0.0, give raw 0.
//  Stage 1, edge with dnn_done=1:
//   - register raw_decision; raw_valid high for exactly the next cycle.
//   - shift raw bit into the WIN-bit history.
//   - vote_count <= vote_count + new - oldest. oldest counts only when fill==WIN.
//   - fill saturates at WIN.
//  Stage 2, edge after a stage-1 update:
//   - FSM evaluates the new vote_count.
//   - vad_valid pulses one cycle, only if fill==WIN.
//   - While fill<WIN: FSM stays SILENCE and no vad_valid is issued.
//  Latency: dnn_done at cycle t -> raw_valid at t+1 -> vad_valid at t+2.
//   dnn_done on every cycle is supported with full throughput.
//  FSM (one evaluation per frame, c = vote_count):
//   - SILENCE: c>=VOTE_ON -> SPEECH. Otherwise stay.
//   - SPEECH: c<=VOTE_OFF -> HANGOVER with hang=HANG (HANG=0: go straight to SILENCE). Otherwise stay.
//   - HANGOVER: c>=VOTE_ON -> SPEECH. Else if hang==0 -> SILENCE. Else hang<=hang-1, stay.
//   - vad_speech = state is SPEECH or HANGOVER, taken after the transition. Held between pulses.
//   - hang_active = state is HANGOVER.
//  clear=1:
//   - next edge zeroes history, fill, vote_count, hang; FSM -> SILENCE; vad_speech -> 0.
//   - Any pending stage-2 evaluation is cancelled.
//  clear and dnn_done in the same cycle: clear wins, the frame is dropped, raw_valid stays 0.
//  Async reset mid-pipeline: pending pulses are discarded with no glitch after release.
//   Reset release is synchronised locally (2-flop).
//  Illegal parameter sets (VOTE_OFF>=VOTE_ON, VOTE_ON>WIN, WIN>32) stop elaboration via $error.
// TESTING
//  1 Reset with rst_n=0, toggle dnn_done -> all outputs 0; after release, no pulses until dnn_done.
//  2 MODE0: 3F800000 -> raw_decision 1; 3F7FFFFF -> 0.
//    MODE1: BF800000 -> 0; 3F000000 -> 1; 3EFFFFFF -> 0.
//  3 Defaults, 8 frames of 1.0f -> no vad_valid for frames 1-7.
//    Frame 8: vad_valid at t+2, vad_speech 1, vote_count 8.
//  4 Then 0.0f frames:
//    - frame 6 (c=2) -> hang_active 1.
//    - frames 7-10 keep vad_speech 1.
//    - frame 11 -> vad_speech 0, hang_active 0.
//    Repeat with HANG=0 -> vad_speech 0 at frame 6.
//  5 In HANGOVER, feed 1.0f until c=5 -> back to SPEECH, hang_active 0.
//    clear together with dnn_done -> no raw_valid, vote_count 0, vad_speech 0.
//  6 dnn_done every cycle for 40 cycles with random codes -> output stream matches a
//    reference model cycle-for-cycle; no pulse lost or duplicated.

Source files
------------

// File: rtl/vad_decision_smoother.sv
// Post-processor for DNN_0 results: float32 -> raw speech bit, sliding-window
// majority vote, then on/off hysteresis with a hangover counter.
module vad_decision_smoother #(
  parameter int          WIN         = 8,
  parameter int          VOTE_ON     = 5,
  parameter int          VOTE_OFF    = 2,
  parameter int          HANG        = 4,
  parameter int          MODE        = 0,
  parameter logic [31:0] SPEECH_CODE = 32'h3F800000,
  parameter logic [31:0] THRESH      = 32'h3F000000
) (
  input  logic                         g_fast_clk,
  input  logic                         rst_n,
  input  logic                         dnn_done,
  input  logic [31:0]                  dnn_return,
  input  logic                         clear,
  output logic                         raw_valid,
  output logic                         raw_decision,
  output logic                         vad_valid,
  output logic                         vad_speech,
  output logic [$clog2(WIN+1)-1:0]     vote_count,
  output logic                         hang_active
);

  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] WIN_C  = CW'(WIN);
  localparam logic [CW-1:0] VON_C  = CW'(VOTE_ON);
  localparam logic [CW-1:0] VOFF_C = CW'(VOTE_OFF);
  localparam logic [7:0]    HANG_C = 8'(HANG);

  generate
    if (WIN < 1 || WIN > 32 || VOTE_OFF >= VOTE_ON || VOTE_ON > WIN ||
        HANG < 0 || HANG > 255 || VOTE_OFF < 0) begin : g_bad_params
      $error("vad_decision_smoother: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {SILENCE, SPEECH, HANGOVER} state_t;

  logic [1:0]     rst_sync;
  logic           rst_int_n;
  logic [WIN-1:0] history;
  logic [CW-1:0]  fill;
  logic           eval_pending;
  logic           raw_bit;
  logic           is_code;
  logic           above_thresh;
  logic           oldest;
  state_t         state;
  logic [7:0]     hang_cnt;

  // Assert asynchronously, release only after two clean edges.
  always_ff @(posedge g_fast_clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // Sign bit must be clear, so -0.0 never qualifies as speech.
  assign is_code      = (dnn_return == SPEECH_CODE);
  assign above_thresh = !dnn_return[31] && (dnn_return[30:0] >= THRESH[30:0]);
  assign raw_bit      = (MODE == 1) ? above_thresh : is_code;
  assign oldest       = (fill == WIN_C) && history[WIN-1];

  always_ff @(posedge g_fast_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      raw_valid    <= 1'b0;
      raw_decision <= 1'b0;
      history      <= '0;
      fill         <= '0;
      vote_count   <= '0;
      eval_pending <= 1'b0;
    end else if (clear) begin
      raw_valid    <= 1'b0;
      history      <= '0;
      fill         <= '0;
      vote_count   <= '0;
      eval_pending <= 1'b0;
    end else begin
      raw_valid    <= dnn_done;
      eval_pending <= dnn_done;
      if (dnn_done) begin
        raw_decision <= raw_bit;
        history      <= WIN'({history, raw_bit});
        vote_count   <= vote_count + CW'(raw_bit) - CW'(oldest);
        if (fill != WIN_C) fill <= fill + CW'(1);
      end
    end
  end

  // Evaluates the vote produced by the previous edge; silent until the window is full.
  always_ff @(posedge g_fast_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= SILENCE;
      hang_cnt    <= '0;
      vad_valid   <= 1'b0;
      vad_speech  <= 1'b0;
      hang_active <= 1'b0;
    end else if (clear) begin
      state       <= SILENCE;
      hang_cnt    <= '0;
      vad_valid   <= 1'b0;
      vad_speech  <= 1'b0;
      hang_active <= 1'b0;
    end else begin
      vad_valid <= 1'b0;
      if (eval_pending && fill == WIN_C) begin
        vad_valid <= 1'b1;
        case (state)
          SILENCE: begin
            if (vote_count >= VON_C) begin
              state      <= SPEECH;
              vad_speech <= 1'b1;
            end
          end
          SPEECH: begin
            if (vote_count <= VOFF_C) begin
              if (HANG_C == 8'd0) begin
                state      <= SILENCE;
                vad_speech <= 1'b0;
              end else begin
                state       <= HANGOVER;
                hang_cnt    <= HANG_C;
                hang_active <= 1'b1;
              end
            end
          end
          HANGOVER: begin
            if (vote_count >= VON_C) begin
              state       <= SPEECH;
              hang_active <= 1'b0;
            end else if (hang_cnt == 8'd0) begin
              state       <= SILENCE;
              vad_speech  <= 1'b0;
              hang_active <= 1'b0;
            end else begin
              hang_cnt <= hang_cnt - 8'd1;
            end
          end
          default: begin
            state       <= SILENCE;
            vad_speech  <= 1'b0;
            hang_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vad_decision_smoother.sv
// Self-checking bench for vad_decision_smoother: directed scenarios plus a
// random full-throughput run against a frame-level reference model.
module tb_vad_decision_smoother;

  localparam int          WIN      = 8;
  localparam int          VOTE_ON  = 5;
  localparam int          VOTE_OFF = 2;
  localparam int          HANG     = 4;
  localparam logic [31:0] ONE      = 32'h3F800000;
  localparam logic [31:0] ZERO     = 32'h00000000;

  logic        clk;
  logic        rst_n;
  logic        dnn_done;
  logic [31:0] dnn_return;
  logic        clear;

  logic       raw_valid, raw_decision, vad_valid, vad_speech, hang_active;
  logic [3:0] vote_count;
  logic       m1_raw_valid, m1_raw_decision, m1_vad_valid, m1_vad_speech, m1_hang_active;
  logic [3:0] m1_vote_count;
  logic       h0_raw_valid, h0_raw_decision, h0_vad_valid, h0_vad_speech, h0_hang_active;
  logic [3:0] h0_vote_count;

  int errors = 0;
  int checks = 0;

  // Frame-level reference model state
  int   hist_q[$];
  bit   m_pending, m_speech, m_hang;
  int   m_hang_left;
  logic e_raw_valid, e_raw_dec, e_vad_valid;

  vad_decision_smoother dut (
    .g_fast_clk(clk), .rst_n(rst_n), .dnn_done(dnn_done), .dnn_return(dnn_return),
    .clear(clear), .raw_valid(raw_valid), .raw_decision(raw_decision),
    .vad_valid(vad_valid), .vad_speech(vad_speech), .vote_count(vote_count),
    .hang_active(hang_active)
  );

  vad_decision_smoother #(.MODE(1)) dut_m1 (
    .g_fast_clk(clk), .rst_n(rst_n), .dnn_done(dnn_done), .dnn_return(dnn_return),
    .clear(clear), .raw_valid(m1_raw_valid), .raw_decision(m1_raw_decision),
    .vad_valid(m1_vad_valid), .vad_speech(m1_vad_speech), .vote_count(m1_vote_count),
    .hang_active(m1_hang_active)
  );

  vad_decision_smoother #(.HANG(0)) dut_h0 (
    .g_fast_clk(clk), .rst_n(rst_n), .dnn_done(dnn_done), .dnn_return(dnn_return),
    .clear(clear), .raw_valid(h0_raw_valid), .raw_decision(h0_raw_decision),
    .vad_valid(h0_vad_valid), .vad_speech(h0_vad_speech), .vote_count(h0_vote_count),
    .hang_active(h0_hang_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int votes();
    int s = 0;
    foreach (hist_q[i]) s += hist_q[i];
    return s;
  endfunction

  task automatic modelReset();
    hist_q.delete();
    m_pending = 0; m_speech = 0; m_hang = 0; m_hang_left = 0;
    e_raw_valid = 0; e_raw_dec = 0; e_vad_valid = 0;
  endtask

  // One clock edge of the reference: smoothing uses the window as it stood before this edge.
  task automatic modelStep(input logic done, input logic [31:0] val, input logic clr);
    int c;
    if (clr) begin
      hist_q.delete();
      m_pending = 0; m_speech = 0; m_hang = 0; m_hang_left = 0;
      e_raw_valid = 0; e_vad_valid = 0;
      return;
    end
    e_vad_valid = 0;
    if (m_pending && hist_q.size() == WIN) begin
      e_vad_valid = 1;
      c = votes();
      if (m_hang) begin
        if (c >= VOTE_ON) begin m_hang = 0; m_speech = 1; end
        else if (m_hang_left == 0) m_hang = 0;
        else m_hang_left--;
      end else if (m_speech) begin
        if (c <= VOTE_OFF) begin
          m_speech = 0;
          if (HANG > 0) begin m_hang = 1; m_hang_left = HANG; end
        end
      end else if (c >= VOTE_ON) begin
        m_speech = 1;
      end
    end
    m_pending   = done;
    e_raw_valid = done;
    if (done) begin
      e_raw_dec = (val == ONE);
      hist_q.push_back(e_raw_dec ? 1 : 0);
      if (hist_q.size() > WIN) void'(hist_q.pop_front());
    end
  endtask

  // Drive one cycle of inputs from a falling edge, then compare everything at the next falling edge.
  task automatic applyStimulus(input logic done, input logic [31:0] val, input logic clr);
    dnn_done   = done;
    dnn_return = val;
    clear      = clr;
    @(posedge clk);
    modelStep(done, val, clr);
    @(negedge clk);
    checkOutput("raw_valid", 32'(raw_valid), 32'(e_raw_valid));
    checkOutput("raw_decision", 32'(raw_decision), 32'(e_raw_dec));
    checkOutput("vad_valid", 32'(vad_valid), 32'(e_vad_valid));
    checkOutput("vad_speech", 32'(vad_speech), 32'(m_speech || m_hang));
    checkOutput("vote_count", 32'(vote_count), 32'(votes()));
    checkOutput("hang_active", 32'(hang_active), 32'(m_hang));
  endtask

  task automatic sendFrame(input logic [31:0] val);
    applyStimulus(1'b1, val, 1'b0);
    applyStimulus(1'b0, ZERO, 1'b0);
  endtask

  typedef struct { logic [31:0] val; logic m0; logic m1; } code_t;
  code_t codes[6] = '{
    '{32'h3F800000, 1'b1, 1'b1}, '{32'h3F7FFFFF, 1'b0, 1'b1},
    '{32'hBF800000, 1'b0, 1'b0}, '{32'h3F000000, 1'b0, 1'b1},
    '{32'h3EFFFFFF, 1'b0, 1'b0}, '{32'h80000000, 1'b0, 1'b0}
  };

  initial begin
    int raw_pulses;
    int vad_pulses;
    logic [31:0] rv;
    rst_n = 1'b0; dnn_done = 1'b0; dnn_return = ZERO; clear = 1'b0;
    modelReset();

    $display("[TB] reset hold with dnn_done toggling");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dnn_done   = ~dnn_done;
      dnn_return = ONE;
      #2;
      checkOutput("rst_raw_valid", 32'(raw_valid), 32'd0);
      checkOutput("rst_vad_valid", 32'(vad_valid), 32'd0);
    end
    @(negedge clk);
    checkOutput("rst_speech", 32'(vad_speech), 32'd0);
    checkOutput("rst_count", 32'(vote_count), 32'd0);
    checkOutput("rst_hang", 32'(hang_active), 32'd0);
    checkOutput("rst_raw_dec", 32'(raw_decision), 32'd0);
    dnn_done = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, ZERO, 1'b0);

    $display("[TB] raw decision codes");
    foreach (codes[i]) begin
      applyStimulus(1'b1, codes[i].val, 1'b0);
      checkOutput("m0_raw", 32'(raw_decision), 32'(codes[i].m0));
      checkOutput("m1_raw", 32'(m1_raw_decision), 32'(codes[i].m1));
      applyStimulus(1'b0, ZERO, 1'b0);
    end
    applyStimulus(1'b0, ZERO, 1'b1);

    $display("[TB] window fill with speech frames");
    for (int k = 1; k <= 8; k++) begin
      sendFrame(ONE);
      if (k < 8) checkOutput("no_vad_early", 32'(vad_valid), 32'd0);
      else begin
        checkOutput("fill_vad_valid", 32'(vad_valid), 32'd1);
        checkOutput("fill_speech", 32'(vad_speech), 32'd1);
        checkOutput("fill_count", 32'(vote_count), 32'd8);
      end
    end

    $display("[TB] speech end and hangover");
    for (int k = 1; k <= 11; k++) begin
      sendFrame(ZERO);
      if (k == 5) checkOutput("h0_speech_f5", 32'(h0_vad_speech), 32'd1);
      if (k == 6) begin
        checkOutput("hang_f6", 32'(hang_active), 32'd1);
        checkOutput("h0_speech_f6", 32'(h0_vad_speech), 32'd0);
      end
      if (k >= 7 && k <= 10) checkOutput("hang_speech", 32'(vad_speech), 32'd1);
      if (k == 11) begin
        checkOutput("end_speech", 32'(vad_speech), 32'd0);
        checkOutput("end_hang", 32'(hang_active), 32'd0);
      end
    end

    $display("[TB] re-entry from hangover, then clear with dnn_done");
    applyStimulus(1'b0, ZERO, 1'b1);
    for (int k = 0; k < 8; k++) sendFrame(ONE);
    for (int k = 0; k < 6; k++) sendFrame(ZERO);
    checkOutput("reentry_hang", 32'(hang_active), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      sendFrame(ONE);
      if (k == 4) checkOutput("reentry_hang_k4", 32'(hang_active), 32'd1);
      if (k == 5) begin
        checkOutput("reentry_hang_k5", 32'(hang_active), 32'd0);
        checkOutput("reentry_speech", 32'(vad_speech), 32'd1);
        checkOutput("reentry_count", 32'(vote_count), 32'd5);
      end
    end
    applyStimulus(1'b1, ONE, 1'b0);
    applyStimulus(1'b1, ONE, 1'b1);
    checkOutput("clr_raw_valid", 32'(raw_valid), 32'd0);
    checkOutput("clr_count", 32'(vote_count), 32'd0);
    checkOutput("clr_speech", 32'(vad_speech), 32'd0);
    applyStimulus(1'b0, ZERO, 1'b0);
    checkOutput("clr_vad_valid", 32'(vad_valid), 32'd0);

    $display("[TB] random back-to-back frames");
    raw_pulses = 0;
    vad_pulses = 0;
    for (int i = 0; i < 42; i++) begin
      case ($urandom_range(0, 2))
        0:       rv = ONE;
        1:       rv = ZERO;
        default: rv = $urandom;
      endcase
      if (i < 40) applyStimulus(1'b1, rv, 1'b0);
      else        applyStimulus(1'b0, ZERO, 1'b0);
      raw_pulses += int'(raw_valid);
      vad_pulses += int'(vad_valid);
    end
    checkOutput("rand_raw_pulses", 32'(raw_pulses), 32'd40);
    checkOutput("rand_vad_pulses", 32'(vad_pulses), 32'd33);

    $display("[TB] async reset mid-pipeline");
    applyStimulus(1'b1, ONE, 1'b0);
    dnn_done = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_raw_valid", 32'(raw_valid), 32'd0);
    checkOutput("midrst_count", 32'(vote_count), 32'd0);
    @(negedge clk);
    checkOutput("midrst_vad_valid", 32'(vad_valid), 32'd0);
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, ZERO, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
